// File: rtl/id_regbank_hazard.sv
// Decode-stage 2**AW x DW register bank with write-through reads and load-use stall/bubble control.
// Optional macro ID_STALL_CNT_EN enables the saturating stall-cycle counter on stall_count.
module id_regbank_hazard #(
    parameter int DW       = 32,
    parameter int AW       = 4,
    parameter int LOAD_LAT = 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          id_valid,
    input  logic [AW-1:0] id_RA,
    input  logic [AW-1:0] id_RB,
    input  logic          id_use_RA,
    input  logic          id_use_RB,
    input  logic [AW-1:0] ex_WC,
    input  logic          ex_W_RB,
    input  logic          ex_is_load,
    input  logic          flush,
    input  logic [AW-1:0] wb_WC,
    input  logic          wb_W_RB,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] out_PRA,
    output logic [DW-1:0] out_PRB,
    output logic          stall,
    output logic          bubble,
    output logic [15:0]   stall_count
);

    localparam int DEPTH = 1 << AW;
    localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, STALL = 1'b1} state_t;

    logic [DW-1:0] r_bank [DEPTH];
    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_rem;
    logic [2:0]    w_rem_nxt;
    logic          w_hazard;
    logic          w_stall;
    logic          w_bubble;

    // Register bank storage; writeback is never blocked by a stall.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bank[i] <= '0;
            end
        end else if (wb_W_RB) begin
            r_bank[wb_WC] <= wb_data;
        end
    end

    // Operand reads with same-cycle bypass of the writeback value.
    always_comb begin
        out_PRA = '0;
        out_PRB = '0;
        if (RESET) begin
            out_PRA = '0;
            out_PRB = '0;
        end else begin
            out_PRA = (wb_W_RB && (wb_WC == id_RA)) ? wb_data : r_bank[id_RA];
            out_PRB = (wb_W_RB && (wb_WC == id_RB)) ? wb_data : r_bank[id_RB];
        end
    end

    assign w_hazard = id_valid & ex_is_load & ex_W_RB &
                      ((id_use_RA & (id_RA == ex_WC)) | (id_use_RB & (id_RB == ex_WC)));

    // Stall FSM state and remaining-cycle register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
            r_rem   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Next-state and Mealy stall/bubble decode; flush always overrides a stall.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_stall     = 1'b0;
        w_bubble    = 1'b0;
        case (r_state)
            IDLE: begin
                if (flush) begin
                    w_bubble = 1'b1;
                end else if (w_hazard) begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                    if (LOAD_LAT > 1) begin
                        w_state_nxt = STALL;
                        w_rem_nxt   = LAT_M1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_stall  = 1'b0;
                    w_bubble = 1'b0;
                end
            end
            STALL: begin
                w_bubble = 1'b1;
                if (flush) begin
                    w_state_nxt = IDLE;
                    w_rem_nxt   = 3'd0;
                end else begin
                    w_stall = 1'b1;
                    if (r_rem <= 3'd1) begin
                        w_state_nxt = IDLE;
                        w_rem_nxt   = 3'd0;
                    end else begin
                        w_rem_nxt = r_rem - 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_rem_nxt   = 3'd0;
            end
        endcase
    end

    assign stall  = w_stall & ~RESET;
    assign bubble = w_bubble | RESET;

`ifdef ID_STALL_CNT_EN
    logic [15:0] r_stall_count;

    // Saturating count of stalled cycles, cleared only by reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_stall_count <= 16'h0000;
        end else if (stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'h0001;
        end
    end

    assign stall_count = r_stall_count;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_id_regbank_hazard.sv
// Directed bench for id_regbank_hazard: two instances (LOAD_LAT=1 and 3) share all inputs.
module tb_id_regbank_hazard;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        id_valid, id_use_RA, id_use_RB;
    logic [3:0]  id_RA, id_RB, ex_WC, wb_WC;
    logic        ex_W_RB, ex_is_load, flush, wb_W_RB;
    logic [31:0] wb_data;

    logic [31:0] pra1, prb1, pra3, prb3;
    logic        stall1, bubble1, stall3, bubble3;
    logic [15:0] cnt1, cnt3;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 CLK = ~CLK;

    id_regbank_hazard #(.DW(32), .AW(4), .LOAD_LAT(1)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .id_valid(id_valid), .id_RA(id_RA), .id_RB(id_RB),
        .id_use_RA(id_use_RA), .id_use_RB(id_use_RB), .ex_WC(ex_WC), .ex_W_RB(ex_W_RB),
        .ex_is_load(ex_is_load), .flush(flush), .wb_WC(wb_WC), .wb_W_RB(wb_W_RB),
        .wb_data(wb_data), .out_PRA(pra1), .out_PRB(prb1), .stall(stall1),
        .bubble(bubble1), .stall_count(cnt1)
    );

    id_regbank_hazard #(.DW(32), .AW(4), .LOAD_LAT(3)) u_dut3 (
        .CLK(CLK), .RESET(RESET), .id_valid(id_valid), .id_RA(id_RA), .id_RB(id_RB),
        .id_use_RA(id_use_RA), .id_use_RB(id_use_RB), .ex_WC(ex_WC), .ex_W_RB(ex_W_RB),
        .ex_is_load(ex_is_load), .flush(flush), .wb_WC(wb_WC), .wb_W_RB(wb_W_RB),
        .wb_data(wb_data), .out_PRA(pra3), .out_PRB(prb3), .stall(stall3),
        .bubble(bubble3), .stall_count(cnt3)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef ID_STALL_CNT_EN
        return 32'(n);
`else
        return 32'(n - n);
`endif
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_hazard(input logic on);
        id_valid   = on;
        ex_is_load = on;
        ex_W_RB    = on;
        ex_WC      = 4'd7;
        id_RA      = 4'd7;
        id_use_RA  = on;
        id_use_RB  = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; flush = 1'b0; wb_W_RB = 1'b0; wb_WC = 4'd0; wb_data = 32'h0;
        id_RB = 4'd0;
        set_hazard(1'b1);
        #12;
        // Reset state: hazard inputs active but reset forces stall=0, bubble=1
        check_val("rst_stall1", {31'b0, stall1}, 32'd0);
        check_val("rst_bubble1", {31'b0, bubble1}, 32'd1);
        check_val("rst_stall3", {31'b0, stall3}, 32'd0);
        check_val("rst_pra", pra3, 32'h0);
        check_val("rst_cnt", {16'b0, cnt3}, 32'h0);
        set_hazard(1'b0);
        id_RA = 4'd0;
        RESET = 1'b0;
        step();
        check_val("idle_bubble", {31'b0, bubble1}, 32'd0);

        // Writeback then read next cycle
        wb_W_RB = 1'b1; wb_WC = 4'd5; wb_data = 32'hDEADBEEF; id_RA = 4'd2;
        step();
        wb_W_RB = 1'b0; id_RA = 4'd5;
        #1;
        check_val("rd_r5", pra1, 32'hDEADBEEF);

        // Write-through on port B before the edge
        wb_W_RB = 1'b1; wb_WC = 4'd3; wb_data = 32'h12345678; id_RB = 4'd3;
        #1;
        check_val("wt_prb", prb3, 32'h12345678);
        check_val("wt_pra_kept", pra3, 32'hDEADBEEF);
        step();
        wb_W_RB = 1'b0;
        #1;
        check_val("stored_r3", prb1, 32'h12345678);

        // Load-use hazard with a concurrent writeback to r9
        set_hazard(1'b1);
        wb_W_RB = 1'b1; wb_WC = 4'd9; wb_data = 32'hAAAA5555;
        #1;
        check_val("hz_stall1", {31'b0, stall1}, 32'd1);
        check_val("hz_bubble1", {31'b0, bubble1}, 32'd1);
        check_val("hz_stall3_c1", {31'b0, stall3}, 32'd1);
        step();
        set_hazard(1'b0); wb_W_RB = 1'b0;
        #1;
        check_val("hz_stall1_end", {31'b0, stall1}, 32'd0);
        check_val("hz_bubble1_end", {31'b0, bubble1}, 32'd0);
        check_val("hz_stall3_c2", {31'b0, stall3}, 32'd1);
        check_val("hz_bubble3_c2", {31'b0, bubble3}, 32'd1);
        step();
        check_val("hz_stall3_c3", {31'b0, stall3}, 32'd1);
        step();
        check_val("hz_stall3_end", {31'b0, stall3}, 32'd0);
        check_val("hz_bubble3_end", {31'b0, bubble3}, 32'd0);
        check_val("cnt1_a", {16'b0, cnt1}, exp_cnt(1));
        check_val("cnt3_a", {16'b0, cnt3}, exp_cnt(3));

        // Flush in the second stall cycle aborts the stall
        set_hazard(1'b1);
        step();
        set_hazard(1'b0); flush = 1'b1;
        #1;
        check_val("fl_stall3", {31'b0, stall3}, 32'd0);
        check_val("fl_bubble3", {31'b0, bubble3}, 32'd1);
        check_val("fl_bubble1", {31'b0, bubble1}, 32'd1);
        step();
        flush = 1'b0;
        #1;
        check_val("fl_idle_stall3", {31'b0, stall3}, 32'd0);
        check_val("fl_idle_bubble3", {31'b0, bubble3}, 32'd0);
        check_val("cnt1_b", {16'b0, cnt1}, exp_cnt(2));
        check_val("cnt3_b", {16'b0, cnt3}, exp_cnt(4));

        // Qualifier cases, all checked combinationally without a clock edge
        set_hazard(1'b1); id_use_RA = 1'b0;
        #1;
        check_val("no_use_ra", {30'b0, stall3, bubble3}, 32'd0);
        set_hazard(1'b1); ex_W_RB = 1'b0;
        #1;
        check_val("no_ex_wrb", {30'b0, stall3, bubble3}, 32'd0);
        set_hazard(1'b1); id_valid = 1'b0;
        #1;
        check_val("no_valid", {30'b0, stall1, bubble1}, 32'd0);
        set_hazard(1'b1); id_use_RA = 1'b0; id_use_RB = 1'b1; id_RB = 4'd7;
        #1;
        check_val("hz_via_rb", {30'b0, stall1, bubble1}, 32'd3);
        set_hazard(1'b1); flush = 1'b1;
        #1;
        check_val("flush_hz", {30'b0, stall3, bubble3}, 32'd1);
        flush = 1'b0; set_hazard(1'b0); id_RA = 4'd9;
        #1;
        check_val("rd_r9", pra1, 32'hAAAA5555);

        // Asynchronous reset in the middle of a stall
        set_hazard(1'b1);
        step();
        check_val("pre_rst_stall3", {31'b0, stall3}, 32'd1);
        RESET = 1'b1;
        #1;
        check_val("mid_rst_stall3", {31'b0, stall3}, 32'd0);
        check_val("mid_rst_bubble3", {31'b0, bubble3}, 32'd1);
        #2;
        RESET = 1'b0; set_hazard(1'b0); id_RA = 4'd5;
        #1;
        check_val("post_rst_stall3", {30'b0, stall3, bubble3}, 32'd0);
        check_val("post_rst_r5", pra3, 32'h0);
        check_val("post_rst_cnt", {16'b0, cnt3}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
